// File: rtl/vram_port_arbiter_if.sv
// Signal bundle between the VRAM port arbiter, its two requesters and the frame-buffer RAM.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface vram_port_arbiter_if #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 40
);
  localparam int IDX_W = $clog2(LINE_WORDS);

  logic              line_req;
  logic [ADDR_W-1:0] line_base;
  logic              line_busy;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic [IDX_W-1:0]  pix_idx;
  logic              overrun;

  logic              gl_valid;
  logic              gl_we;
  logic [ADDR_W-1:0] gl_addr;
  logic [DATA_W-1:0] gl_wdata;
  logic              gl_ready;
  logic [DATA_W-1:0] gl_rdata;
  logic              gl_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  line_req, line_base, gl_valid, gl_we, gl_addr, gl_wdata, mem_rdata,
    output line_busy, pix_data, pix_valid, pix_idx, overrun,
           gl_ready, gl_rdata, gl_rvalid, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output line_req, line_base, gl_valid, gl_we, gl_addr, gl_wdata, mem_rdata,
    input  line_busy, pix_data, pix_valid, pix_idx, overrun,
           gl_ready, gl_rdata, gl_rvalid, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: uninterruptible LINE_WORDS read bursts for the VGA line
// fetcher, single-word reads/writes for the draw engine whenever the port is idle.
module vram_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 40
) (
  input  logic                 Clk,
  input  logic                 Reset,
  vram_port_arbiter_if.slave   bus
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LINE  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              pix_valid_q;
  logic              gl_rvalid_q;
  logic              overrun_q;
  logic [DATA_W-1:0] pix_hold_q;
  logic [DATA_W-1:0] gl_hold_q;
  logic              gl_grant;

  // Burst FSM, read-return flags and the hold registers behind the data outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      pix_valid_q <= 1'b0;
      gl_rvalid_q <= 1'b0;
      overrun_q   <= 1'b0;
      pix_hold_q  <= '0;
      gl_hold_q   <= '0;
    end else begin
      overrun_q   <= bus.line_req && (state_q != IDLE);
      pix_valid_q <= (state_q == LINE);
      gl_rvalid_q <= gl_grant && !bus.gl_we;
      if (pix_valid_q) begin
        pix_hold_q <= bus.mem_rdata;
      end
      if (gl_rvalid_q) begin
        gl_hold_q <= bus.mem_rdata;
      end
      case (state_q)
        IDLE: begin
          if (bus.line_req) begin
            base_q  <= bus.line_base;
            cnt_q   <= '0;
            state_q <= LINE;
          end
        end
        LINE: begin
          idx_q <= cnt_q;
          if (cnt_q == LAST_IDX) begin
            state_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + IDX_W'(1);
          end
        end
        DRAIN: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM port steering; grant is masked during reset so the port is quiet while Reset is high.
  always_comb begin
    gl_grant      = (state_q == IDLE) && !bus.line_req && !Reset && bus.gl_valid;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    case (state_q)
      LINE: begin
        bus.mem_addr = base_q + ADDR_W'(cnt_q);
      end
      IDLE: begin
        if (gl_grant) begin
          bus.mem_addr  = bus.gl_addr;
          bus.mem_we    = bus.gl_we;
          bus.mem_wdata = bus.gl_we ? bus.gl_wdata : '0;
        end else begin
          bus.mem_addr = '0;
        end
      end
      default: begin
        bus.mem_addr = '0;
      end
    endcase
  end

  // RAM data is only valid the cycle after the read, so the valid cycle bypasses the hold register.
  assign bus.gl_ready  = (state_q == IDLE) && !bus.line_req && !Reset;
  assign bus.line_busy = (state_q != IDLE);
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_idx   = idx_q;
  assign bus.pix_data  = pix_valid_q ? bus.mem_rdata : pix_hold_q;
  assign bus.gl_rvalid = gl_rvalid_q;
  assign bus.gl_rdata  = gl_rvalid_q ? bus.mem_rdata : gl_hold_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter with LINE_WORDS=4: table-driven draw-engine
// accesses, hand-written burst/overrun/reset sequences and a read-data scoreboard.
module tb_vram_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LW = 4;
  localparam int IW = 2;

  logic Clk = 1'b0;
  logic Reset;
  logic ram_clr;

  always #5 Clk = ~Clk;

  vram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) bus ();

  vram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } pix_exp_t;

  pix_exp_t      pix_q[$];
  logic [DW-1:0] gl_q[$];
  logic [DW-1:0] shadow [logic [AW-1:0]];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - 16'h0100;
    if (a >= 16'h0100 && a <= 16'h0103) return 16'h00A0 + off;
    return a ^ 16'hC3C3;
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous single-port RAM with 1-cycle read latency.
  logic [DW-1:0]   ram [65536];
  logic [65535:0]  wrote;
  always @(posedge Clk) begin
    if (ram_clr) begin
      wrote <= '0;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr]   <= bus.mem_wdata;
      wrote[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= wrote[bus.mem_addr] ? ram[bus.mem_addr] : init_val(bus.mem_addr);
  end

  // Scoreboard: every valid word must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (bus.pix_valid) begin
      if (pix_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pix_unexpected: got pix_valid with data 0x%0h, expected none", bus.pix_data);
      end else begin
        pix_exp_t e;
        e = pix_q.pop_front();
        chk("pix_data", 32'(bus.pix_data), 32'(e.data));
        chk("pix_idx", 32'(bus.pix_idx), 32'(e.idx));
      end
    end
    if (bus.gl_rvalid) begin
      if (gl_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL gl_unexpected: got gl_rvalid with data 0x%0h, expected none", bus.gl_rdata);
      end else begin
        logic [DW-1:0] g;
        g = gl_q.pop_front();
        chk("gl_rdata", 32'(bus.gl_rdata), 32'(g));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_gl(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.gl_valid = v;
    bus.gl_we    = we;
    bus.gl_addr  = a;
    bus.gl_wdata = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_line_busy"}, 32'(bus.line_busy), 32'd0);
    chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 32'd0);
    chk({tag, "_pix_data"},  32'(bus.pix_data),  32'd0);
    chk({tag, "_pix_idx"},   32'(bus.pix_idx),   32'd0);
    chk({tag, "_overrun"},   32'(bus.overrun),   32'd0);
    chk({tag, "_gl_rvalid"}, 32'(bus.gl_rvalid), 32'd0);
    chk({tag, "_gl_rdata"},  32'(bus.gl_rdata),  32'd0);
    chk({tag, "_gl_ready"},  32'(bus.gl_ready),  32'd0);
    chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
  endtask

  // Full burst from IDLE at cycle T; optional pending draw access (1=read, 2=write) and a
  // second line_req at T+2. Caller is at the drive point of cycle T.
  task automatic burst(input logic [AW-1:0] base, input int gl_mode,
                       input logic [AW-1:0] ga, input logic [DW-1:0] gd, input bit ovr);
    logic [AW-1:0] a;
    pix_exp_t e;
    bus.line_req  = 1'b1;
    bus.line_base = base;
    set_gl(gl_mode != 0, gl_mode == 2, ga, gd);
    for (int i = 0; i < LW; i++) begin
      a = base + 16'(i);
      e.idx  = IW'(i);
      e.data = model_rd(a);
      pix_q.push_back(e);
    end
    #3;
    chk("burst_T_busy",  32'(bus.line_busy), 32'd0);
    chk("burst_T_ready", 32'(bus.gl_ready),  32'd0);
    chk("burst_T_we",    32'(bus.mem_we),    32'd0);
    chk("burst_T_addr",  32'(bus.mem_addr),  32'd0);
    tick();
    bus.line_req = 1'b0;
    for (int c = 1; c <= LW + 1; c++) begin
      if (ovr) bus.line_req = (c == 2);
      a = (c <= LW) ? base + 16'(c - 1) : 16'h0000;
      #3;
      chk("burst_busy",      32'(bus.line_busy), 32'd1);
      chk("burst_ready",     32'(bus.gl_ready),  32'd0);
      chk("burst_mem_we",    32'(bus.mem_we),    32'd0);
      chk("burst_mem_addr",  32'(bus.mem_addr),  32'(a));
      chk("burst_pix_valid", 32'(bus.pix_valid), 32'(c >= 2));
      chk("burst_overrun",   32'(bus.overrun),   32'(ovr && c == 3));
      tick();
      bus.line_req = 1'b0;
    end
    #3;
    chk("post_busy",      32'(bus.line_busy), 32'd0);
    chk("post_pix_valid", 32'(bus.pix_valid), 32'd0);
    chk("post_overrun",   32'(bus.overrun),   32'd0);
    chk("post_ready",     32'(bus.gl_ready),  32'd1);
    chk("post_pix_hold",  32'(bus.pix_data),  32'(model_rd(base + 16'(LW - 1))));
    chk("post_pix_idx",   32'(bus.pix_idx),   32'(LW - 1));
    if (gl_mode != 0) begin
      chk("post_gl_addr", 32'(bus.mem_addr), 32'(ga));
      chk("post_gl_we",   32'(bus.mem_we),   32'(gl_mode == 2));
      if (gl_mode == 2) shadow[ga] = gd;
      else gl_q.push_back(model_rd(ga));
    end
    tick();
    set_gl(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  typedef struct {
    logic          v;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          exp_rvalid;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 16'h0042, 16'hBEEF, 1'b1, 16'h0042, 16'hBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0, 16'h0042, 16'h0000, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h0042, 16'h1111, 1'b0, 16'h0042, 16'h0000, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 16'h0077, 16'h2222, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 16'h1234, 16'h5555, 1'b1, 16'h1234, 16'h5555, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 16'h1234, 16'h0000, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h0100, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 16'hFFFF, 16'h0F0F, 1'b1, 16'hFFFF, 16'h0F0F, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 1'b0};

    Reset   = 1'b1;
    ram_clr = 1'b1;
    bus.line_req  = 1'b0;
    bus.line_base = 16'h0000;
    set_gl(1'b0, 1'b0, 16'h0000, 16'h0000);
    #2;
    chk_all_zero("por");
    repeat (2) @(posedge Clk);
    #1;
    Reset   = 1'b0;
    ram_clr = 1'b0;
    #3;
    chk("rel_ready", 32'(bus.gl_ready),  32'd1);
    chk("rel_busy",  32'(bus.line_busy), 32'd0);
    tick();

    // Draw-engine accesses while the port is idle.
    for (int i = 0; i < 9; i++) begin
      set_gl(vecs[i].v, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].v && vecs[i].we) shadow[vecs[i].addr] = vecs[i].wdata;
      if (vecs[i].v && !vecs[i].we) gl_q.push_back(model_rd(vecs[i].addr));
      #3;
      chk("vec_ready",     32'(bus.gl_ready),  32'd1);
      chk("vec_mem_we",    32'(bus.mem_we),    32'(vecs[i].exp_we));
      chk("vec_mem_addr",  32'(bus.mem_addr),  32'(vecs[i].exp_addr));
      chk("vec_mem_wdata", 32'(bus.mem_wdata), 32'(vecs[i].exp_wdata));
      chk("vec_rvalid",    32'(bus.gl_rvalid), 32'(vecs[i].exp_rvalid));
      tick();
    end
    set_gl(1'b0, 1'b0, 16'h0000, 16'h0000);
    #3;
    chk("tail_rvalid", 32'(bus.gl_rvalid), 32'd1);
    tick();
    #3;
    chk("hold_rvalid", 32'(bus.gl_rvalid), 32'd0);
    chk("hold_rdata",  32'(bus.gl_rdata),  32'h0F0F);
    tick();

    // Asynchronous reset in the middle of a cycle.
    #2;
    Reset = 1'b1;
    #1;
    chk_all_zero("async");
    tick();
    Reset = 1'b0;
    #3;
    chk("arel_ready", 32'(bus.gl_ready), 32'd1);
    tick();

    burst(16'h0100, 0, 16'h0000, 16'h0000, 1'b0);
    burst(16'h0200, 1, 16'h0042, 16'h0000, 1'b0);
    burst(16'h0300, 2, 16'h0300, 16'h7777, 1'b1);
    burst(16'h0300, 0, 16'h0000, 16'h0000, 1'b0);
    burst(16'hFFFE, 0, 16'h0000, 16'h0000, 1'b0);

    // Wrapping burst aborted by reset at T+3: only word 0 is delivered.
    begin
      pix_exp_t e;
      bus.line_req  = 1'b1;
      bus.line_base = 16'hFFFE;
      e.idx  = 2'd0;
      e.data = model_rd(16'hFFFE);
      pix_q.push_back(e);
      tick();
      bus.line_req = 1'b0;
      #3;
      chk("abort_addr0", 32'(bus.mem_addr), 32'hFFFE);
      tick();
      #3;
      chk("abort_addr1", 32'(bus.mem_addr),  32'hFFFF);
      chk("abort_pv",    32'(bus.pix_valid), 32'd1);
      tick();
      #1;
      chk("abort_addr2", 32'(bus.mem_addr), 32'h0000);
      #1;
      Reset = 1'b1;
      #1;
      chk("abort_rst_pv",   32'(bus.pix_valid), 32'd0);
      chk("abort_rst_busy", 32'(bus.line_busy), 32'd0);
      chk("abort_rst_addr", 32'(bus.mem_addr),  32'd0);
      tick();
      Reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
        #3;
        chk("abort_idle_pv",    32'(bus.pix_valid), 32'd0);
        chk("abort_idle_ready", 32'(bus.gl_ready),  32'd1);
        tick();
      end
    end

    burst(16'h0100, 0, 16'h0000, 16'h0000, 1'b0);
    repeat (2) tick();
    chk("pix_queue_empty", 32'(pix_q.size()), 32'd0);
    chk("gl_queue_empty",  32'(gl_q.size()),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
